// File: rtl/hacd_reg_arbiter.sv
// hacd_reg_arbiter
// Round-robin arbiter sharing the 32-bit HACD register port between
// NUM_REQ requesters. A beat issued with lock=1 keeps the grant for the
// following beat, so a 64-bit access split into two beats stays atomic.
//
// Handshake: a requester raises valid with stable fields and holds them
// until it sees its req_ready_o pulse. Downstream, a beat completes in the
// cycle where s_valid_o && s_ready_i; req_rdata_o is valid in that cycle.
//
// Optional feature: define HACD_REG_ARB_TIMEOUT_EN to enable a watchdog
// that completes a stalled beat with an error after TIMEOUT_CYCLES.

module hacd_reg_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                    cfg_clk_i,
    input  logic                    cfg_rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [NUM_REQ-1:0]      req_lock_i,
    input  logic [NUM_REQ*32-1:0]   req_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_wdata_i,
    input  logic [NUM_REQ*4-1:0]    req_wstrb_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [31:0]             req_rdata_o,
    output logic [NUM_REQ-1:0]      req_err_o,
    output logic                    s_valid_o,
    output logic                    s_write_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_wdata_o,
    output logic [3:0]              s_wstrb_o,
    input  logic                    s_ready_i,
    input  logic [31:0]             s_rdata_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic                    busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PW-1:0]        r_gidx;
    logic [PW-1:0]        r_rr_ptr;

    logic                 w_any;
    logic [PW-1:0]        w_pick;
    logic [PW-1:0]        w_ptr_next;
    logic                 w_busy;
    logic                 w_gvalid;
    logic                 w_glock;
    logic                 w_hs;
    logic                 w_to;

    // Pick the first requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        logic [PW-1:0] v_idx;
        w_any  = 1'b0;
        w_pick = '0;
        v_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid_i[v_idx]) begin
                w_any  = 1'b1;
                w_pick = v_idx;
            end
        end
    end

    assign w_ptr_next = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + PW'(1);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_gvalid   = req_valid_i[r_gidx];
    assign w_glock    = req_lock_i[r_gidx];

`ifdef HACD_REG_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_to = w_busy && (r_cnt == 16'(TIMEOUT_CYCLES));

    // Watchdog: count stalled cycles of the current beat, restart per beat.
    always_ff @(posedge cfg_clk_i or negedge cfg_rst_ni) begin
        if (!cfg_rst_ni) begin
            r_cnt <= '0;
        end else if (!w_busy || w_hs) begin
            r_cnt <= '0;
        end else if (s_valid_o && !s_ready_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign req_err_o = w_to ? r_grant : '0;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
    assign w_to         = 1'b0;
    assign req_err_o    = '0;
`endif

    // The grantee's fields go straight through; nothing is driven when idle.
    assign s_valid_o   = w_busy && w_gvalid && !w_to;
    assign s_write_o   = w_busy && req_write_i[r_gidx];
    assign s_addr_o    = w_busy ? req_addr_i[32*r_gidx +: 32]  : '0;
    assign s_wdata_o   = w_busy ? req_wdata_i[32*r_gidx +: 32] : '0;
    assign s_wstrb_o   = w_busy ? req_wstrb_i[4*r_gidx +: 4]   : '0;
    assign w_hs        = s_valid_o && s_ready_i;

    assign req_ready_o = (w_hs || w_to) ? r_grant : '0;
    assign req_rdata_o = w_to ? ERR_RDATA : (w_hs ? s_rdata_i : '0);
    assign grant_o     = r_grant;
    assign busy_o      = w_busy;

    // Arbitration FSM: IDLE grants, GRANT/LOCKED forward beats and release.
    always_ff @(posedge cfg_clk_i or negedge cfg_rst_ni) begin
        if (!cfg_rst_ni) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_pick;
                        r_gidx  <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT, ST_LOCKED: begin
                    if (w_to) begin
                        // Forced release: the lock is dropped and rr_ptr moves on.
                        r_rr_ptr <= w_ptr_next;
                        r_grant  <= '0;
                        r_state  <= ST_IDLE;
                    end else if (!w_gvalid) begin
                        // Grantee abandoned the beat: re-arbitrate, priority unchanged.
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_hs) begin
                        if (w_glock) begin
                            r_state <= ST_LOCKED;
                        end else begin
                            r_rr_ptr <= w_ptr_next;
                            r_grant  <= '0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hacd_reg_arbiter.sv
// Testbench for hacd_reg_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Directed table of per-cycle vectors, hand-written multi-cycle sequences,
// then randomized traffic checked against a transaction-level model.

module tb_hacd_reg_arbiter;

    localparam int          N    = 2;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef HACD_REG_ARB_TIMEOUT_EN
    localparam int STALL = 6;
`else
    localparam int STALL = 10;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      valid, write, lock;
    logic [N*32-1:0]   addr, wdata;
    logic [N*4-1:0]    wstrb;
    logic              s_ready;
    logic [31:0]       s_rdata;
    logic [N-1:0]      req_ready, req_err, grant;
    logic [31:0]       req_rdata;
    logic              s_valid, s_write, busy;
    logic [31:0]       s_addr, s_wdata;
    logic [3:0]        s_wstrb;

    int n_checks;
    int n_fail;

    hacd_reg_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERRD)
    ) dut (
        .cfg_clk_i   (clk),
        .cfg_rst_ni  (rst_n),
        .req_valid_i (valid),
        .req_write_i (write),
        .req_lock_i  (lock),
        .req_addr_i  (addr),
        .req_wdata_i (wdata),
        .req_wstrb_i (wstrb),
        .req_ready_o (req_ready),
        .req_rdata_o (req_rdata),
        .req_err_o   (req_err),
        .s_valid_o   (s_valid),
        .s_write_o   (s_write),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_wstrb_o   (s_wstrb),
        .s_ready_i   (s_ready),
        .s_rdata_i   (s_rdata),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        valid[i]          = v;
        write[i]          = w;
        lock[i]           = l;
        addr[i*32 +: 32]  = a;
        wdata[i*32 +: 32] = d;
        wstrb[i*4 +: 4]   = s;
    endtask

    task automatic clear_inputs();
        valid   = '0;
        write   = '0;
        lock    = '0;
        addr    = '0;
        wdata   = '0;
        wstrb   = '0;
        s_ready = 1'b0;
        s_rdata = '0;
    endtask

    task automatic new_beat(input int i);
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [31:0] a1;
        logic        rdy;
        logic [31:0] rd;
        logic        e_sv;
        logic [31:0] e_addr;
        logic [1:0]  e_rdy;
        logic [31:0] e_rd;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [31:0] a1,
                                input logic rdy, input logic [31:0] rd, input logic e_sv,
                                input logic [31:0] e_addr, input logic [1:0] e_rdy,
                                input logic [31:0] e_rd, input logic [1:0] e_gnt,
                                input logic e_busy);
        vec_t t;
        t.v = v; t.l = l; t.a1 = a1; t.rdy = rdy; t.rd = rd;
        t.e_sv = e_sv; t.e_addr = e_addr; t.e_rdy = e_rdy; t.e_rd = e_rd;
        t.e_gnt = e_gnt; t.e_busy = e_busy;
        return t;
    endfunction

    vec_t tbl[18];

    // ---------------- reference model ----------------
    int m_owner;
    int m_ptr;
    int m_cnt;

    // scoreboard for round-robin order
    logic [N-1:0] exp_q[$];

    // misc bench variables
    logic [31:0]  a0_v, a1_v;
    logic [N-1:0] seen_rdy;
    logic [N-1:0] one_v;
    logic [N-1:0] exp_head;
    int           n_done;
    int           gi;
    logic         bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        one_v    = 1;
        clear_inputs();
        rst_n = 1'b0;

        // ---- reset state, with requests already pending ----
        valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_err", req_err, 0);
        chk("rst_s_addr", s_addr, 0);
        clear_inputs();
        #1 rst_n = 1'b1;
        next_cycle();

        // ---- table: single read, locked pair, back-to-back, abandoned beat ----
        tbl[0]  = mk(2'b00, 2'b00, 32'h20, 1'b0, 32'h0,        0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[1]  = mk(2'b01, 2'b00, 32'h20, 1'b1, 32'h12345678, 0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[2]  = mk(2'b01, 2'b00, 32'h20, 1'b1, 32'h12345678, 1, 32'h10, 2'b01, 32'h12345678, 2'b01, 1);
        tbl[3]  = mk(2'b00, 2'b00, 32'h20, 1'b1, 32'h12345678, 0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[4]  = mk(2'b11, 2'b10, 32'h20, 1'b1, 32'h1111,     0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[5]  = mk(2'b11, 2'b10, 32'h20, 1'b1, 32'h1111,     1, 32'h20, 2'b10, 32'h1111,     2'b10, 1);
        tbl[6]  = mk(2'b11, 2'b00, 32'h24, 1'b1, 32'h2222,     1, 32'h24, 2'b10, 32'h2222,     2'b10, 1);
        tbl[7]  = mk(2'b01, 2'b00, 32'h24, 1'b1, 32'h3333,     0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[8]  = mk(2'b01, 2'b00, 32'h24, 1'b1, 32'h3333,     1, 32'h10, 2'b01, 32'h3333,     2'b01, 1);
        tbl[9]  = mk(2'b00, 2'b00, 32'h24, 1'b0, 32'h0,        0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[10] = mk(2'b10, 2'b00, 32'h30, 1'b0, 32'h4444,     0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[11] = mk(2'b10, 2'b00, 32'h30, 1'b0, 32'h4444,     1, 32'h30, 2'b00, 32'h0,        2'b10, 1);
        tbl[12] = mk(2'b00, 2'b00, 32'h30, 1'b0, 32'h4444,     0, 32'h30, 2'b00, 32'h0,        2'b10, 1);
        tbl[13] = mk(2'b11, 2'b00, 32'h30, 1'b1, 32'h5555,     0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[14] = mk(2'b11, 2'b00, 32'h30, 1'b1, 32'h5555,     1, 32'h30, 2'b10, 32'h5555,     2'b10, 1);
        tbl[15] = mk(2'b01, 2'b00, 32'h30, 1'b1, 32'h6666,     0, 32'h0,  2'b00, 32'h0,        2'b00, 0);
        tbl[16] = mk(2'b01, 2'b00, 32'h30, 1'b1, 32'h6666,     1, 32'h10, 2'b01, 32'h6666,     2'b01, 1);
        tbl[17] = mk(2'b00, 2'b00, 32'h30, 1'b0, 32'h0,        0, 32'h0,  2'b00, 32'h0,        2'b00, 0);

        addr[31:0] = 32'h10;
        for (int r = 0; r < 18; r++) begin
            valid          = tbl[r].v;
            lock           = tbl[r].l;
            addr[63:32]    = tbl[r].a1;
            s_ready        = tbl[r].rdy;
            s_rdata        = tbl[r].rd;
            @(negedge clk);
            chk($sformatf("tbl%0d_s_valid", r), s_valid, tbl[r].e_sv);
            chk($sformatf("tbl%0d_s_addr", r), s_addr, tbl[r].e_addr);
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_rdata", r), req_rdata, tbl[r].e_rd);
            chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_gnt);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            next_cycle();
        end
        clear_inputs();

        // ---- stall: fields hold, ready only in the handshake cycle ----
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_0001, 4'h5);
        s_ready = 1'b0;
        next_cycle();
        for (int k = 0; k < STALL; k++) begin
            @(negedge clk);
            chk("stall_s_valid", s_valid, 1);
            chk("stall_s_addr", s_addr, 32'h40);
            chk("stall_s_wdata", s_wdata, 32'hCAFE_0001);
            chk("stall_s_wstrb", s_wstrb, 4'h5);
            chk("stall_s_write", s_write, 1);
            chk("stall_ready", req_ready, 0);
            next_cycle();
        end
        s_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_ready", req_ready, 2'b10);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("stall_after_ready", req_ready, 0);
        chk("stall_after_busy", busy, 0);

        // ---- round-robin: continuous unlocked writes from both ----
        do_reset();
        a0_v = 32'h100;
        a1_v = 32'h200;
        set_req(0, 1'b1, 1'b1, 1'b0, a0_v, 32'hA0, 4'h3);
        set_req(1, 1'b1, 1'b1, 1'b0, a1_v, 32'hB0, 4'hC);
        s_ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(N'(k % 2));
        n_done = 0;
        for (int c = 0; c < 40 && n_done < 8; c++) begin
            @(negedge clk);
            seen_rdy = req_ready;
            if (s_valid && s_ready) begin
                gi = grant[1] ? 1 : 0;
                exp_head = exp_q.pop_front();
                chk("rr_order", N'(gi), exp_head);
                chk("rr_addr", s_addr, gi ? a1_v : a0_v);
                chk("rr_wstrb", s_wstrb, gi ? 4'hC : 4'h3);
                n_done++;
            end
            next_cycle();
            if (seen_rdy[0]) begin a0_v = a0_v + 4; addr[31:0]  = a0_v; end
            if (seen_rdy[1]) begin a1_v = a1_v + 4; addr[63:32] = a1_v; end
        end
        chk("rr_done", n_done, 8);
        clear_inputs();
        next_cycle();

        // ---- mid-operation reset while LOCKED ----
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        s_ready = 1'b1;
        next_cycle();
        next_cycle();                 // req0 completes, rr_ptr now 1
        valid = '0;
        next_cycle();
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h11, 4'hF);
        next_cycle();                 // arbitration
        next_cycle();                 // locked beat completes
        s_ready = 1'b0;
        @(negedge clk);
        chk("lk_busy", busy, 1);
        chk("lk_grant", grant, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_s_valid", s_valid, 0);
        chk("mrst_grant", grant, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_rdata", req_rdata, 0);
        chk("mrst_s_addr", s_addr, 0);
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        s_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("mrst_ptr0_grant", grant, 2'b01);
        next_cycle();
        valid = 2'b10;
        next_cycle();
        @(negedge clk);
        chk("mrst_req1_grant", grant, 2'b10);
        chk("mrst_req1_ready", req_ready, 2'b10);
        chk("mrst_req1_addr", s_addr, 32'h20);
        next_cycle();
        clear_inputs();
        next_cycle();

        // ---- stuck register file ----
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 4'h0);
        s_ready = 1'b0;
        s_rdata = 32'h77;
        next_cycle();
`ifdef HACD_REG_ARB_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("to_wait_s_valid", s_valid, 1);
            chk("to_wait_err", req_err, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("to_s_valid", s_valid, 0);
        chk("to_ready", req_ready, 2'b01);
        chk("to_err", req_err, 2'b01);
        chk("to_rdata", req_rdata, ERRD);
        next_cycle();
        valid = '0;
        @(negedge clk);
        chk("to_idle_busy", busy, 0);
        chk("to_idle_err", req_err, 0);
`else
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_err !== 0 || req_ready !== 0) bad = 1'b1;
            next_cycle();
        end
        chk("nto_no_pulse", bad, 0);
        @(negedge clk);
        chk("nto_busy", busy, 1);
        chk("nto_s_valid", s_valid, 1);
        next_cycle();
        valid = '0;
        next_cycle();
`endif
        clear_inputs();
        next_cycle();

        // ---- randomized traffic vs. transaction-level model ----
        do_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic         e_sv, e_wr, e_busy, timed;
            logic [31:0]  e_addr, e_wd, e_rd;
            logic [3:0]   e_ws;
            logic [N-1:0] e_rdy, e_err, e_gnt;
            int           o;
            @(negedge clk);
            e_sv = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_ws = 0;
            e_rdy = 0; e_err = 0; e_rd = 0; timed = 0;
            e_busy = (m_owner >= 0);
            e_gnt  = (m_owner >= 0) ? (one_v << m_owner) : '0;
            if (m_owner >= 0) begin
                o = m_owner;
`ifdef HACD_REG_ARB_TIMEOUT_EN
                timed = (m_cnt == TO);
`endif
                if (timed) begin
                    e_rdy   = one_v << o;
                    e_err   = one_v << o;
                    e_rd    = ERRD;
                    m_ptr   = (o + 1) % N;
                    m_owner = -1;
                end else begin
                    e_sv   = valid[o];
                    e_wr   = write[o];
                    e_addr = addr[o*32 +: 32];
                    e_wd   = wdata[o*32 +: 32];
                    e_ws   = wstrb[o*4 +: 4];
                    if (!valid[o]) begin
                        m_owner = -1;
                    end else if (s_ready) begin
                        e_rdy = one_v << o;
                        e_rd  = s_rdata;
                        m_cnt = 0;
                        if (!lock[o]) begin
                            m_ptr   = (o + 1) % N;
                            m_owner = -1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_cnt = 0;
            end
            chk("rnd_s_valid", s_valid, e_sv);
            chk("rnd_ready", req_ready, e_rdy);
            chk("rnd_err", req_err, e_err);
            chk("rnd_rdata", req_rdata, e_rd);
            chk("rnd_grant", grant, e_gnt);
            chk("rnd_busy", busy, e_busy);
            if (e_sv) begin
                chk("rnd_s_addr", s_addr, e_addr);
                chk("rnd_s_wdata", s_wdata, e_wd);
                chk("rnd_s_wstrb", s_wstrb, e_ws);
                chk("rnd_s_write", s_write, e_wr);
            end
            seen_rdy = req_ready;
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (seen_rdy[i]) begin
                    if ((lock[i] && $urandom_range(0, 3) != 0) || $urandom_range(0, 2) == 0)
                        new_beat(i);
                    else
                        valid[i] = 1'b0;
                end else if (!valid[i]) begin
                    if ($urandom_range(0, 2) == 0) new_beat(i);
                end else if ($urandom_range(0, 63) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            s_ready = ($urandom_range(0, 3) != 0);
            s_rdata = $urandom;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
